// File: rtl/parity_frame_scheduler_if.sv
// Requester / serial-frame bundle for parity_frame_scheduler.
// master: the requester side driving req and data words.
// slave : the scheduler.
interface parity_frame_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [1:0]        gnt;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_last;
  logic              busy;

  modport master (
    output req, data0, data1,
    input  gnt, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  req, data0, data1,
    output gnt, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/parity_frame_scheduler.sv
// Two-requester round-robin scheduler that serialises the winning word
// LSB first followed by one parity bit.
//
// state  | meaning
// IDLE   | no frame; waiting for any req bit
// SHIFT  | DATA_W data bits on ser_out, LSB first
// PARITY | single parity bit, ser_last high
//
// Every output is a flop loaded from next-state values, so outputs change
// only on clock edges (or asynchronously to zero on reset).
module parity_frame_scheduler #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic                    clk,
  input logic                    reset_n,
  parity_frame_scheduler_if.slave bus
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] sreg, sreg_nx;
  logic              acc, acc_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              last_win, last_win_nx;
  logic              win;

  logic [1:0]        gnt_q, gnt_nx;
  logic              ser_out_q, ser_out_nx;
  logic              valid_q, valid_nx;
  logic              last_q, last_nx;
  logic              busy_q, busy_nx;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nx    = state;
    sreg_nx     = sreg;
    acc_nx      = acc;
    cnt_nx      = cnt;
    last_win_nx = last_win;
    gnt_nx      = 2'b00;
    win         = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // On contention the requester that did not win last time goes next.
          win         = (bus.req == 2'b11) ? ~last_win : bus.req[1];
          sreg_nx     = win ? bus.data1 : bus.data0;
          acc_nx      = 1'b0;
          cnt_nx      = '0;
          last_win_nx = win;
          gnt_nx      = win ? 2'b10 : 2'b01;
          state_nx    = SHIFT;
        end
      end
      SHIFT: begin
        sreg_nx = sreg >> 1;
        acc_nx  = acc ^ sreg[0];
        if (cnt == CW'(DATA_W - 1)) begin
          state_nx = PARITY;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PARITY: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    busy_nx  = (state_nx != IDLE);
    valid_nx = (state_nx != IDLE);
    last_nx  = (state_nx == PARITY);
    if (state_nx == SHIFT) begin
      ser_out_nx = sreg_nx[0];
    end else if (state_nx == PARITY) begin
      ser_out_nx = acc_nx ^ ODD_PARITY;
    end else begin
      ser_out_nx = 1'b0;
    end
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      acc       <= 1'b0;
      cnt       <= '0;
      last_win  <= 1'b1;
      gnt_q     <= 2'b00;
      ser_out_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      last_win  <= last_win_nx;
      gnt_q     <= gnt_nx;
      ser_out_q <= ser_out_nx;
      valid_q   <= valid_nx;
      last_q    <= last_nx;
      busy_q    <= busy_nx;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = valid_q;
  assign bus.ser_last  = last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Self-checking bench: two schedulers (even and odd parity) driven by the
// same stimulus, checked against a frame-level reference model.
module tb_parity_frame_scheduler;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  parity_frame_scheduler_if #(.DATA_W(W)) bus_e ();
  parity_frame_scheduler_if #(.DATA_W(W)) bus_o ();

  parity_frame_scheduler #(.DATA_W(W), .ODD_PARITY(1'b0)) dut_e (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_e)
  );

  parity_frame_scheduler #(.DATA_W(W), .ODD_PARITY(1'b1)) dut_o (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_o)
  );

  int checks = 0;
  int errors = 0;
  int run_e = 0;
  int run_o = 0;
  int last_model = 1;   // index of the requester granted most recently
  logic [1:0] cur_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1);
    cur_req     = r;
    bus_e.req   = r;
    bus_o.req   = r;
    bus_e.data0 = d0;
    bus_o.data0 = d0;
    bus_e.data1 = d1;
    bus_o.data1 = d1;
  endtask

  // Advance to the next falling edge and apply the always-true properties.
  task automatic tick();
    @(negedge clk);
    chk("gnt_onehot_e", 32'(bus_e.gnt == 2'b11), 32'd0);
    chk("gnt_onehot_o", 32'(bus_o.gnt == 2'b11), 32'd0);
    chk("last_implies_valid_e", 32'(bus_e.ser_last & ~bus_e.ser_valid), 32'd0);
    chk("last_implies_valid_o", 32'(bus_o.ser_last & ~bus_o.ser_valid), 32'd0);
    if (bus_e.ser_valid === 1'b1) run_e++; else run_e = 0;
    if (bus_o.ser_valid === 1'b1) run_o++; else run_o = 0;
    if (bus_e.ser_last === 1'b1) begin
      chk("frame_len_e", 32'(run_e), 32'(W + 1));
      run_e = 0;
    end
    if (bus_o.ser_last === 1'b1) begin
      chk("frame_len_o", 32'(run_o), 32'(W + 1));
      run_o = 0;
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] g, input logic oe,
                            input logic oo, input logic v, input logic l, input logic b);
    chk({tag, "_gnt_e"},   32'(bus_e.gnt),       32'(g));
    chk({tag, "_gnt_o"},   32'(bus_o.gnt),       32'(g));
    chk({tag, "_out_e"},   32'(bus_e.ser_out),   32'(oe));
    chk({tag, "_out_o"},   32'(bus_o.ser_out),   32'(oo));
    chk({tag, "_valid_e"}, 32'(bus_e.ser_valid), 32'(v));
    chk({tag, "_valid_o"}, 32'(bus_o.ser_valid), 32'(v));
    chk({tag, "_last_e"},  32'(bus_e.ser_last),  32'(l));
    chk({tag, "_last_o"},  32'(bus_o.ser_last),  32'(l));
    chk({tag, "_busy_e"},  32'(bus_e.busy),      32'(b));
    chk({tag, "_busy_o"},  32'(bus_o.busy),      32'(b));
  endtask

  // Call at a falling edge with both DUTs idle. Runs one frame and the
  // trailing idle cycle. hold keeps req asserted throughout; scramble
  // inverts both data words in the middle of the frame.
  task automatic do_frame(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input bit hold, input bit scramble);
    logic [W-1:0] word;
    logic [1:0]   g_exp;
    int           w;
    int           ones;
    logic         pe;
    drive(r, d0, d1);
    if (r == 2'b01)      w = 0;
    else if (r == 2'b10) w = 1;
    else                 w = (last_model == 1) ? 0 : 1;
    last_model = w;
    word  = (w == 1) ? d1 : d0;
    g_exp = (w == 1) ? 2'b10 : 2'b01;
    ones  = 0;
    for (int k = 0; k < W; k++) ones += int'(word[k]);
    pe = ((ones % 2) == 1);
    for (int i = 0; i < W; i++) begin
      tick();
      expect_out("shift", (i == 0) ? g_exp : 2'b00, word[i], word[i], 1'b1, 1'b0, 1'b1);
      if (i == 0 && !hold) drive(2'b00, d0, d1);
      if (i == 3 && scramble) drive(cur_req, ~d0, ~d1);
    end
    tick();
    expect_out("parity", 2'b00, pe, ~pe, 1'b1, 1'b1, 1'b1);
    tick();
    expect_out("gap", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0]   r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           h;
    bit           s;

    // Power-on reset.
    reset_n = 1'b0;
    drive(2'b00, '0, '0);
    #1;
    expect_out("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    tick();
    expect_out("post_reset_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sustained contention alternates 0,1,0,1 starting with requester 0.
    do_frame(2'b11, 8'h01, 8'h80, 1'b1, 1'b0);
    do_frame(2'b11, 8'h01, 8'h80, 1'b1, 1'b0);
    do_frame(2'b11, 8'h01, 8'h80, 1'b1, 1'b0);
    do_frame(2'b11, 8'h01, 8'h80, 1'b0, 1'b0);

    // Known words: A5 (even parity 0), 07 (even 1 / odd 0).
    do_frame(2'b01, 8'hA5, 8'h00, 1'b0, 1'b0);
    do_frame(2'b01, 8'h07, 8'h00, 1'b0, 1'b0);

    // Data changing mid-frame must not disturb the captured word.
    do_frame(2'b01, 8'hFF, 8'h00, 1'b0, 1'b1);

    // Randomised frames.
    for (int n = 0; n < 30; n++) begin
      r = 2'($urandom_range(1, 3));
      a = W'($urandom);
      b = W'($urandom);
      h = (n == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      do_frame(r, a, b, h, s);
    end

    // Reset during the 4th SHIFT cycle aborts the frame without a parity bit.
    a = W'($urandom);
    drive(2'b01, a, 8'h00);
    last_model = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("pre_abort", (i == 0) ? 2'b01 : 2'b00, a[i], a[i], 1'b1, 1'b0, 1'b1);
      if (i == 0) drive(2'b00, a, 8'h00);
    end
    #2 reset_n = 1'b0;
    run_e = 0;
    run_o = 0;
    #1;
    expect_out("abort", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    b = W'($urandom);
    drive(2'b10, 8'h00, b);
    #1 reset_n = 1'b1;
    last_model = 1;
    // req is already high at the first edge after release, so it is granted there.
    do_frame(2'b10, 8'h00, b, 1'b0, 1'b0);
    do_frame(2'b11, 8'h3C, 8'hC3, 1'b0, 1'b0);
    do_frame(2'b11, 8'h3C, 8'hC3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_scheduler.md
PARITY_FRAME_SCHEDULER -- requirements
Module: parity_frame_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each requester word (min 2).
REQ-002 SHALL have parameter ODD_PARITY, default 0: 0 = even parity bit, 1 = odd parity bit.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  2  per-requester frame request, bit i = requester i.
REQ-007 SHALL have port data0  input  DATA_W  requester 0 word, held stable while req[0]=1.
REQ-008 SHALL have port data1  input  DATA_W  requester 1 word, held stable while req[1]=1.
REQ-009 SHALL have port gnt  output  2  registered one-cycle grant pulse, one-hot or zero.
REQ-010 SHALL have port ser_out  output  1  serial frame bit, LSB first, then parity.
REQ-011 SHALL have port ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-012 SHALL have port ser_last  output  1  this cycle carries the parity bit.
REQ-013 SHALL have port busy  output  1  high from grant cycle through parity cycle.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, PARITY; all outputs driven from registers.
REQ-015 IDLE: when req != 0 at a clock edge, SHALL capture the winner's word into a DATA_W shift register, clear the parity accumulator, and enter SHIFT.
REQ-016 Arbitration SHALL be round-robin: single request wins; if req=2'b11, the requester not granted last wins.
REQ-017 Last-grant pointer SHALL reset to 1, so requester 0 wins the first contention after reset.
REQ-018 gnt[winner] SHALL be high exactly in the first SHIFT cycle, and only then.
REQ-019 SHIFT SHALL last exactly DATA_W cycles; ser_out = current LSB, ser_valid=1; each edge shifts right by one and XORs that bit into the accumulator.
REQ-020 Bit counter SHALL count 0..DATA_W-1 with no wrap past DATA_W-1; at count DATA_W-1 the next state SHALL be PARITY.
REQ-021 PARITY SHALL last one cycle: ser_out = XOR of all DATA_W bits XOR ODD_PARITY, ser_valid=1, ser_last=1; next state IDLE unconditionally.
REQ-022 Each frame SHALL be DATA_W+1 consecutive valid cycles followed by at least one IDLE cycle with ser_valid=0 and busy=0.
REQ-023 Requester SHALL deassert req on the edge after seeing gnt; req still high in a later IDLE cycle SHALL count as a new request.
REQ-024 Changes of req or data during SHIFT/PARITY SHALL not affect the frame in progress.
REQ-025 In IDLE: ser_out=0, ser_valid=0, ser_last=0, gnt=0, busy=0.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, gnt=0, ser_out=0, ser_valid=0, ser_last=0, busy=0, counter=0, accumulator=0, shift register=0, pointer=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame, with no parity bit emitted; the first request after release SHALL start a fresh frame.
REQ-028 Deassertion of reset_n SHALL take effect at the next rising clk edge; no grant in that same cycle unless req is already high at that edge.

Verification
REQ-029 DATA_W=8, ODD_PARITY=0, req=01, data0=8'hA5 -> gnt=01 one cycle; ser_out 1,0,1,0,0,1,0,1 then parity 0 with ser_last=1; busy high for 9 cycles.
REQ-030 ODD_PARITY=1, data0=8'h07 -> bits 1,1,1,0,0,0,0,0, parity bit 0; with ODD_PARITY=0 the same word gives parity bit 1.
REQ-031 After reset, req=11 held, data0=8'h01, data1=8'h80 -> grant order 0,1,0,1; each frame 9 valid cycles; at least one idle cycle between frames.
REQ-032 reset_n pulsed low at the 4th SHIFT cycle -> all outputs 0 asynchronously, no ser_last; after release, req=10 gives gnt=10 and a complete frame.
REQ-033 data0 toggled from 8'hFF to 8'h00 mid-frame -> emitted frame is still all ones, parity 0 (even).
REQ-034 Assertion check: gnt never 2'b11; ser_last implies ser_valid; ser_valid count per frame = DATA_W+1.
